// File: rtl/wb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// The state encoding matches the one-hot grant encoding, so the FSM state
// can be read directly on gnt_o.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Watchdog counter. Counts enabled cycles and raises a one-cycle expired
// pulse on the cycle whose count would reach LIMIT. The counter then restarts.
// A clear in the same cycle suppresses the pulse, so an ack arriving in the
// expiry cycle takes priority.
module wb_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign expired = en && !clr && (count == CW'(LIMIT - 1));

    // Count register: clear wins, expiry restarts, otherwise count when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || expired) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter (m0 = instruction fetch,
// m1 = data access). The grant is held for a whole cyc. Every handover
// passes through one IDLE cycle. A watchdog aborts accesses that the slave
// never acknowledges.
//
// Handshake: an access completes in a cycle where the granted master has
// stb high and the slave returns ack. The ack is forwarded only to the
// granted master, gated with that master's stb. Read data is forwarded
// to both masters and is valid only when accompanied by ack.
module wb_arbiter_2m
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          RR_EN      = 1'b1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    // master 0
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    // master 1
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    // slave
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    input  logic                    s_ack_i,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    // current grant, one-hot
    output logic [1:0]              gnt_o
);

    arb_state_t state, next_state;
    logic       last_m1;   // 1 when master 1 held the most recent grant
    logic [1:0] err_q;     // registered timeout error, bit per master
    logic       expired;
    logic       cnt_en;
    logic       cnt_clr;

    // The watchdog runs while a strobe waits for ack and is held clear in IDLE.
    assign cnt_en  = s_stb_o && !s_ack_i;
    assign cnt_clr = s_ack_i || (state == IDLE);

    wb_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (reset),
        .en      (cnt_en),
        .clr     (cnt_clr),
        .expired (expired)
    );

    // Next-state: arbitrate only from IDLE, hold the grant while cyc stays high.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (RR_EN) begin
                        next_state = last_m1 ? GNT0 : GNT1;
                    end else begin
                        next_state = GNT1;
                    end
                end else if (m0_cyc_i) begin
                    next_state = GNT0;
                end else if (m1_cyc_i) begin
                    next_state = GNT1;
                end
            end
            GNT0: begin
                if (expired || !m0_cyc_i) begin
                    next_state = IDLE;
                end
            end
            GNT1: begin
                if (expired || !m1_cyc_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, round-robin history and error pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
            err_q   <= 2'b00;
        end else begin
            state <= next_state;
            if (state == GNT0 && next_state == IDLE) begin
                last_m1 <= 1'b0;
            end else if (state == GNT1 && next_state == IDLE) begin
                last_m1 <= 1'b1;
            end
            if (expired) begin
                err_q <= (state == GNT1) ? GNT_M1 : GNT_M0;
            end else begin
                err_q <= 2'b00;
            end
        end
    end

    // Forwarding: steer the granted master onto the slave port and route ack back.
    always_comb begin
        gnt_o    = GNT_NONE;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state)
            GNT0: begin
                gnt_o    = GNT_M0;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i && m0_stb_i;
            end
            GNT1: begin
                gnt_o    = GNT_M1;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i && m1_stb_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_err_o = err_q[0];
    assign m1_err_o = err_q[1];

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m. Two instances share every input:
// u_rr (round-robin) and u_fp (fixed priority), both with TIMEOUT=4.
// Each scenario checks only the instance it targets.
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // shared stimulus
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_dat, m1_dat, s_dat;
    logic [3:0]    m0_sel, m1_sel;

    // round-robin instance outputs
    logic          r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
    logic [DW-1:0] r_m0_dat, r_m1_dat, r_s_dat;
    logic          r_s_cyc, r_s_stb, r_s_we;
    logic [AW-1:0] r_s_adr;
    logic [3:0]    r_s_sel;
    logic [1:0]    r_gnt;

    // fixed-priority instance outputs
    logic          f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
    logic [DW-1:0] f_m0_dat, f_m1_dat, f_s_dat;
    logic          f_s_cyc, f_s_stb, f_s_we;
    logic [AW-1:0] f_s_adr;
    logic [3:0]    f_s_sel;
    logic [1:0]    f_gnt;

    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_EN(1'b1), .TIMEOUT(4)) u_rr (
        .clk(clk), .reset(reset),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(r_m0_ack), .m0_err_o(r_m0_err),
        .m0_dat_o(r_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(r_m1_ack), .m1_err_o(r_m1_err),
        .m1_dat_o(r_m1_dat),
        .s_cyc_o(r_s_cyc), .s_stb_o(r_s_stb), .s_we_o(r_s_we), .s_adr_o(r_s_adr),
        .s_dat_o(r_s_dat), .s_sel_o(r_s_sel), .s_ack_i(s_ack), .s_dat_i(s_dat),
        .gnt_o(r_gnt)
    );

    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_EN(1'b0), .TIMEOUT(4)) u_fp (
        .clk(clk), .reset(reset),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
        .m0_dat_o(f_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
        .m1_dat_o(f_m1_dat),
        .s_cyc_o(f_s_cyc), .s_stb_o(f_s_stb), .s_we_o(f_s_we), .s_adr_o(f_s_adr),
        .s_dat_o(f_s_dat), .s_sel_o(f_s_sel), .s_ack_i(s_ack), .s_dat_i(s_dat),
        .gnt_o(f_gnt)
    );

    // scoreboard counters
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
    endtask

    // 4-cycle transaction on the fixed-priority instance, called in the
    // first granted cycle; ack arrives in cycle 4.
    task automatic xact4_fp(input bit is_m1, input logic [31:0] rdata);
        for (int i = 0; i < 3; i++) begin
            check("fp_wait_ack", is_m1 ? f_m1_ack : f_m0_ack, 0);
            tick();
        end
        s_ack = 1'b1;
        s_dat = rdata;
        #1;
        check("fp_ack", is_m1 ? f_m1_ack : f_m0_ack, 1);
        check("fp_other_ack", is_m1 ? f_m0_ack : f_m1_ack, 0);
        check("fp_rdata", is_m1 ? f_m1_dat : f_m0_dat, rdata);
        tick();
        s_ack = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
        s_ack  = 0; s_dat = '0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_gnt", r_gnt, 0);
        check("rst_s_cyc", r_s_cyc, 0);
        check("rst_s_stb", r_s_stb, 0);
        check("rst_m0_err", r_m0_err, 0);
        check("rst_m1_err", r_m1_err, 0);
        check("rst_m0_ack", r_m0_ack, 0);
        tick();
        reset = 1'b1;

        // single master read, ack on 3rd strobe cycle
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0000; m0_sel = 4'hf;
        #1;
        check("t1_idle_gnt", r_gnt, 0);
        tick();
        check("t1_gnt", r_gnt, 2'b01);
        check("t1_adr", r_s_adr, 32'h8000_0000);
        check("t1_ack_c1", r_m0_ack, 0);
        tick();
        check("t1_ack_c2", r_m0_ack, 0);
        tick();
        s_ack = 1; s_dat = 32'h0000_0013;
        #1;
        check("t1_ack_c3", r_m0_ack, 1);
        check("t1_rdata", r_m0_dat, 32'h13);
        check("t1_m1_ack", r_m1_ack, 0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        check("t1_ack_after", r_m0_ack, 0);
        check("t1_gnt_hold", r_gnt, 2'b01);
        tick();
        check("t1_idle", r_gnt, 0);

        // simultaneous request, round-robin
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = A0;
        m1_cyc = 1; m1_stb = 1; m1_adr = A1;
        tick();
        check("t2_rr_first", r_gnt, 2'b01);
        check("t2_rr_adr", r_s_adr, A0);
        check("t2_fp_first", f_gnt, 2'b10);
        check("t2_fp_adr", f_s_adr, A1);
        m0_cyc = 0; m0_stb = 0;
        tick();
        check("t2_handover_idle", r_gnt, 0);
        tick();
        check("t2_rr_second", r_gnt, 2'b10);
        check("t2_rr_adr2", r_s_adr, A1);
        m1_cyc = 0; m1_stb = 0;
        tick();
        check("t2_idle2", r_gnt, 0);
        m0_cyc = 1; m1_cyc = 1;
        tick();
        check("t2_rr_third", r_gnt, 2'b01);
        m0_cyc = 0; m1_cyc = 0;
        tick();

        // fixed priority with continuous requests
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = A0;
        m1_cyc = 1; m1_stb = 1; m1_adr = A1;
        tick();
        check("t3_fp_gnt1", f_gnt, 2'b10);
        xact4_fp(1'b1, 32'h0000_00a1);
        m1_cyc = 0; m1_stb = 0;
        tick();
        check("t3_fp_idle", f_gnt, 0);
        m1_cyc = 1; m1_stb = 1;
        tick();
        check("t3_fp_tie_again", f_gnt, 2'b10);
        xact4_fp(1'b1, 32'h0000_00a2);
        m1_cyc = 0; m1_stb = 0;
        tick();
        check("t3_fp_idle2", f_gnt, 0);
        tick();
        check("t3_fp_m0", f_gnt, 2'b01);
        check("t3_fp_m0_adr", f_s_adr, A0);
        xact4_fp(1'b0, 32'h0000_00b0);
        m0_cyc = 0; m0_stb = 0;
        tick();

        // no preemption, with a burst of strobes on m0
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = A0;
        tick();
        check("t4_gnt0", r_gnt, 2'b01);
        m1_cyc = 1; m1_stb = 1; m1_adr = A1;
        for (int i = 0; i < 6; i++) begin
            s_ack = (i % 2 == 1);
            #1;
            check("t4_hold_gnt", r_gnt, 2'b01);
            check("t4_hold_adr", r_s_adr, A0);
            check("t4_burst_ack", r_m0_ack, (i % 2 == 1));
            tick();
        end
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        check("t4_idle", r_gnt, 0);
        check("t4_idle_cyc", r_s_cyc, 0);
        tick();
        check("t4_gnt1", r_gnt, 2'b10);
        check("t4_adr1", r_s_adr, A1);

        // timeout on m1: slave never acks
        for (int i = 0; i < 4; i++) begin
            check("t5_no_err_yet", r_m1_err, 0);
            check("t5_gnt_held", r_gnt, 2'b10);
            tick();
        end
        check("t5_err", r_m1_err, 1);
        check("t5_err_m0", r_m0_err, 0);
        check("t5_abort_gnt", r_gnt, 0);
        check("t5_abort_cyc", r_s_cyc, 0);
        m1_cyc = 0; m1_stb = 0;
        tick();
        check("t5_err_pulse", r_m1_err, 0);

        // ack in the expiry cycle wins over timeout
        m1_cyc = 1; m1_stb = 1;
        tick();
        check("t5b_gnt", r_gnt, 2'b10);
        for (int i = 0; i < 3; i++) tick();
        s_ack = 1;
        #1;
        check("t5b_ack", r_m1_ack, 1);
        tick();
        s_ack = 0;
        #1;
        check("t5b_no_err", r_m1_err, 0);
        check("t5b_gnt_kept", r_gnt, 2'b10);
        m1_cyc = 0; m1_stb = 0;
        tick();
        tick();

        // asynchronous reset mid-access
        m1_cyc = 1; m1_stb = 1;
        tick();
        check("t6_gnt1", r_gnt, 2'b10);
        check("t6_cyc", r_s_cyc, 1);
        #1;
        reset = 1'b0;
        #1;
        check("t6_async_cyc", r_s_cyc, 0);
        check("t6_async_stb", r_s_stb, 0);
        check("t6_async_gnt", r_gnt, 0);
        m0_cyc = 1; m0_stb = 1;
        tick();
        reset = 1'b1;
        tick();
        check("t6_tie_m0", r_gnt, 2'b01);
        check("t6_fp_tie_m1", f_gnt, 2'b10);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
